collision_ctrl: RTL and testbench
=================================

# collision_ctrl

Per-frame collision and game-state controller sitting downstream of the moving-object pixel-flag generators (crocodile, player sprite) on the VGA pixel path. It samples the registered object-in flags against the visible raster and latches any overlap within a frame. At each frame boundary it updates the lives counter, the survival score and a four-state game FSM. Its outputs drive the display overlay and object-reset logic.

## Interface
- `LIVES`, 3: lives loaded on start; legal range 1–7.
- `INV_FRAMES`, 60: invulnerability length after a hit, in frames; legal range 1–255.
- `H_VIS`, 640: visible pixels per line.
- `V_VIS`, 480: visible lines per frame.
- `clk` in 1: pixel clock, the same clock that drives the object generators.
- `rst_n` in 1: asynchronous, active-low reset.
- `hc` in 10: horizontal pixel counter, in phase with the object generators' `hc`.
- `vc` in 10: vertical line counter.
- `CrocIn` in 1: crocodile pixel flag. It is registered upstream, so it lags `hc`/`vc` by one cycle.
- `FrogIn` in 1: player pixel flag, with the same one-cycle lag as `CrocIn`.
- `Start` in 1: synchronous start/restart request, level-sampled each cycle.
- `State` out 2: 0 IDLE, 1 PLAY, 2 HIT, 3 OVER.
- `Lives` out 3: remaining lives.
- `Score` out 16: frames survived, saturating.
- `Flash` out 1: blink enable for the player sprite while in HIT.
- `FrameTick` out 1: one-cycle pulse at each frame boundary.

## Operation
- **Visibility alignment**
  - `vis_q` is registered as `(hc < H_VIS) && (vc < V_VIS)`.
  - A pixel overlap is `vis_q & CrocIn & FrogIn` in the same cycle. This aligns the window with the flags' one-cycle lag.
- **Frame boundary**
  - `FrameTick` is registered and asserted for the single cycle after `hc == 0 && vc == V_VIS` is observed.
  - Exactly one tick occurs per frame.
- **Overlap latch `hit_f`**
  - Set by any pixel overlap.
  - Cleared on the cycle `FrameTick` is high. An overlap in that same cycle is impossible, because the tick falls in vertical blank.
- **FSM**, evaluated every cycle; frame actions occur only when `FrameTick` is high.
  - IDLE: `Start` → PLAY, `Lives = LIVES`, `Score = 0`. Otherwise stay.
  - PLAY, on tick:
    - `Score` increments, saturating at 0xFFFF.
    - If `hit_f`: `Lives` decrements.
    - If `Lives` was 1, go to OVER.
    - Otherwise go to HIT with `inv_cnt = INV_FRAMES`.
  - HIT, on tick:
    - `Score` increments, saturating.
    - `inv_cnt` decrements; when it was 1, go to PLAY.
    - `hit_f` is ignored.
  - OVER: `Lives` and `Score` are frozen. `Start` → PLAY with `Lives = LIVES`, `Score = 0`, `hit_f` cleared.
  - `Start` is ignored in PLAY and HIT.
  - `Start` and `FrameTick` in the same cycle in IDLE or OVER: the start action wins and no score increment occurs.
- **Flash**
  - Equals `inv_cnt[3]` while in HIT; 0 in all other states.
  - This gives an 8-frame on/off blink.
- **Widths**
  - `inv_cnt` is 8 bits.
  - `Lives` never underflows: a decrement from 1 always exits to OVER with `Lives = 0`.
- **Reset**
  - Asynchronous, any cycle, including mid-frame or mid-HIT.
  - Forces IDLE, `Lives = 0`, `Score = 0`, `Flash = 0`, `FrameTick = 0`, `hit_f = 0`, `inv_cnt = 0`, `vis_q = 0`.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Overlap to `hit_f`: 1 cycle.
- `hit_f` to `Lives`/`State` change: on the `FrameTick` cycle; outputs update 1 cycle after that.
- `Start` to `State = PLAY`: 1 cycle.
- Boundary to `FrameTick`: 1 cycle after `hc == 0, vc == V_VIS`.
- After reset release, the first `FrameTick` is the first boundary encountered; no partial-frame suppression is applied.

## Test plan
- **Reset and start.** Assert `rst_n = 0` mid-frame, release, pulse `Start` one cycle → `State = 1`, `Lives = 3`, `Score = 0`. After 5 full 800×525 frames → `Score = 5`.
- **Single hit.** In PLAY, hold `CrocIn = FrogIn = 1` for 1 cycle at `hc = 100`, `vc = 200` → after the next `FrameTick`, `Lives = 2`, `State = 2`. Exactly 60 ticks later → `State = 1`. `Flash` toggles every 8 frames during HIT.
- **Blanking rejection.** Overlap only at `hc = 700`, or only at `vc = 500` → `Lives` unchanged and `State` stays 1.
- **Invulnerability.** Continuous overlap every frame from the first hit → `Lives` goes 3→2 at the first tick, 2→1 after 60 frames plus 1, then `State = 3` with `Lives = 0` on the following hit frame. `Score` freezes in OVER.
- **Restart.** In OVER, assert `Start` in the same cycle as `FrameTick` → `State = 1`, `Lives = 3`, `Score = 0` (not 1).
- **Saturation and async reset.** Preload via a long run or force `Score = 0xFFFE`. Two ticks → `0xFFFF`, then stays at `0xFFFF`. Assert `rst_n` low in HIT → all outputs are 0 and `State = 0` immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/collision_if.sv
// rtl/collision_if.sv - raster/object-flag inputs and game-state outputs of the collision controller
interface collision_if;
    logic [9:0]  hc;
    logic [9:0]  vc;
    logic        CrocIn;
    logic        FrogIn;
    logic        Start;
    logic [1:0]  State;
    logic [2:0]  Lives;
    logic [15:0] Score;
    logic        Flash;
    logic        FrameTick;

    modport master (
        output hc, vc, CrocIn, FrogIn, Start,
        input  State, Lives, Score, Flash, FrameTick
    );

    modport slave (
        input  hc, vc, CrocIn, FrogIn, Start,
        output State, Lives, Score, Flash, FrameTick
    );
endinterface

// File: rtl/collision_ctrl.sv
// rtl/collision_ctrl.sv - per-frame collision latch, lives/score counters and game FSM
module collision_ctrl #(
    parameter int LIVES      = 3,
    parameter int INV_FRAMES = 60,
    parameter int H_VIS      = 640,
    parameter int V_VIS      = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    collision_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, HIT = 2'd2, OVER = 2'd3} stateT;

    localparam logic [2:0] LIVES_INIT = 3'(LIVES);
    localparam logic [7:0] INV_INIT   = 8'(INV_FRAMES);
    localparam logic [9:0] H_LIM      = 10'(H_VIS);
    localparam logic [9:0] V_LIM      = 10'(V_VIS);

    stateT       state;
    logic        visQ;
    logic        hitF;
    logic        tickQ;
    logic        flashQ;
    logic [2:0]  livesQ;
    logic [15:0] scoreQ;
    logic [7:0]  invCnt;

    // visQ is one cycle late, matching the registered object flags
    wire        overlap  = visQ & bus.CrocIn & bus.FrogIn;
    wire        startNow = bus.Start && (state == IDLE || state == OVER);
    wire [15:0] scoreInc = (scoreQ == 16'hFFFF) ? scoreQ : scoreQ + 16'd1;
    wire [7:0]  invDec   = invCnt - 8'd1;

    assign bus.State     = state;
    assign bus.Lives     = livesQ;
    assign bus.Score     = scoreQ;
    assign bus.Flash     = flashQ;
    assign bus.FrameTick = tickQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            visQ   <= 1'b0;
            hitF   <= 1'b0;
            tickQ  <= 1'b0;
            flashQ <= 1'b0;
            livesQ <= 3'd0;
            scoreQ <= 16'd0;
            invCnt <= 8'd0;
        end else begin
            visQ  <= (bus.hc < H_LIM) && (bus.vc < V_LIM);
            tickQ <= (bus.hc == 10'd0) && (bus.vc == V_LIM);

            if (tickQ || startNow)
                hitF <= 1'b0;
            else if (overlap)
                hitF <= 1'b1;

            case (state)
                IDLE, OVER: begin
                    // start wins over a coincident tick: no score step here
                    if (bus.Start) begin
                        state  <= PLAY;
                        livesQ <= LIVES_INIT;
                        scoreQ <= 16'd0;
                        flashQ <= 1'b0;
                        invCnt <= 8'd0;
                    end
                end
                PLAY: begin
                    if (tickQ) begin
                        scoreQ <= scoreInc;
                        if (hitF) begin
                            livesQ <= livesQ - 3'd1;
                            if (livesQ == 3'd1) begin
                                state <= OVER;
                            end else begin
                                state  <= HIT;
                                invCnt <= INV_INIT;
                                flashQ <= INV_INIT[3];
                            end
                        end
                    end
                end
                HIT: begin
                    if (tickQ) begin
                        scoreQ <= scoreInc;
                        invCnt <= invDec;
                        flashQ <= invDec[3];
                        if (invCnt == 8'd1)
                            state <= PLAY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_collision_ctrl.sv
// tb/tb_collision_ctrl.sv - table-driven frame-level checks of collision_ctrl on a shrunken raster
module tb_collision_ctrl;
    localparam int HV    = 16;
    localparam int VV    = 8;
    localparam int HTOT  = 20;
    localparam int VTOT  = 10;
    localparam int FRAME = HTOT * VTOT;

    localparam logic [1:0] ACT_NONE    = 2'd0;
    localparam logic [1:0] ACT_RESTART = 2'd1;
    localparam logic [1:0] ACT_FORCE   = 2'd2;

    typedef struct {
        logic [1:0]  act;
        logic        ovEn;
        logic        ovOnce;
        logic [9:0]  ovH;
        logic [9:0]  ovV;
        int          nTicks;
        logic [1:0]  expState;
        logic [2:0]  expLives;
        logic [15:0] expScore;
        logic        expFlash;
    } vecT;

    logic clk;
    logic rst_n;
    logic ovEn, ovOnce;
    logic [9:0] ovH, ovV;
    int total, bad;
    vecT vecs[20];

    collision_if cif();

    collision_ctrl #(.LIVES(3), .INV_FRAMES(60), .H_VIS(HV), .V_VIS(VV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // flags presented this cycle describe the pixel that was on hc/vc last cycle
    task automatic step();
        logic f;
        @(posedge clk);
        #1;
        f = ovEn && (cif.hc == ovH) && (cif.vc == ovV);
        if (f && ovOnce) ovEn = 1'b0;
        cif.CrocIn = f;
        cif.FrogIn = f;
        if (cif.hc == 10'(HTOT - 1)) begin
            cif.hc = 10'd0;
            cif.vc = (cif.vc == 10'(VTOT - 1)) ? 10'd0 : cif.vc + 10'd1;
        end else begin
            cif.hc = cif.hc + 10'd1;
        end
    endtask

    task automatic wait_tick(output logic ok);
        int budget;
        budget = 0;
        while (!cif.FrameTick && budget < 2 * FRAME) begin
            step();
            budget++;
        end
        ok = cif.FrameTick;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL tick wait: got no FrameTick want one within %0d cycles", 2 * FRAME);
        end
    endtask

    task automatic run_ticks(input int n);
        logic ok;
        for (int k = 0; k < n; k++) begin
            wait_tick(ok);
            if (!ok) return;
            step();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " State"}, 32'(cif.State), 32'd0);
        chk({tag, " Lives"}, 32'(cif.Lives), 32'd0);
        chk({tag, " Score"}, 32'(cif.Score), 32'd0);
        chk({tag, " Flash"}, 32'(cif.Flash), 32'd0);
        chk({tag, " FrameTick"}, 32'(cif.FrameTick), 32'd0);
    endtask

    initial begin
        logic ok;
        total = 0;
        bad   = 0;
        ovEn = 1'b0; ovOnce = 1'b0; ovH = 10'd0; ovV = 10'd0;

        //        act          en    once  ovH     ovV    n   st    lv    score        fl
        vecs[0]  = '{ACT_NONE,    1'b0, 1'b0, 10'd0,  10'd0, 5,  2'd1, 3'd3, 16'd5,       1'b0};
        vecs[1]  = '{ACT_NONE,    1'b1, 1'b1, 10'd5,  10'd3, 1,  2'd2, 3'd2, 16'd6,       1'b1};
        vecs[2]  = '{ACT_NONE,    1'b0, 1'b0, 10'd0,  10'd0, 4,  2'd2, 3'd2, 16'd10,      1'b1};
        vecs[3]  = '{ACT_NONE,    1'b0, 1'b0, 10'd0,  10'd0, 1,  2'd2, 3'd2, 16'd11,      1'b0};
        vecs[4]  = '{ACT_NONE,    1'b0, 1'b0, 10'd0,  10'd0, 8,  2'd2, 3'd2, 16'd19,      1'b1};
        vecs[5]  = '{ACT_NONE,    1'b0, 1'b0, 10'd0,  10'd0, 46, 2'd2, 3'd2, 16'd65,      1'b0};
        vecs[6]  = '{ACT_NONE,    1'b0, 1'b0, 10'd0,  10'd0, 1,  2'd1, 3'd2, 16'd66,      1'b0};
        vecs[7]  = '{ACT_NONE,    1'b1, 1'b1, 10'd16, 10'd3, 1,  2'd1, 3'd2, 16'd67,      1'b0};
        vecs[8]  = '{ACT_NONE,    1'b1, 1'b1, 10'd5,  10'd8, 1,  2'd1, 3'd2, 16'd68,      1'b0};
        vecs[9]  = '{ACT_NONE,    1'b1, 1'b1, 10'd18, 10'd9, 1,  2'd1, 3'd2, 16'd69,      1'b0};
        vecs[10] = '{ACT_NONE,    1'b1, 1'b0, 10'd15, 10'd7, 1,  2'd2, 3'd1, 16'd70,      1'b1};
        vecs[11] = '{ACT_NONE,    1'b1, 1'b0, 10'd15, 10'd7, 60, 2'd1, 3'd1, 16'd130,     1'b0};
        vecs[12] = '{ACT_NONE,    1'b1, 1'b0, 10'd15, 10'd7, 1,  2'd3, 3'd0, 16'd131,     1'b0};
        vecs[13] = '{ACT_NONE,    1'b1, 1'b0, 10'd15, 10'd7, 3,  2'd3, 3'd0, 16'd131,     1'b0};
        vecs[14] = '{ACT_RESTART, 1'b1, 1'b0, 10'd15, 10'd7, 0,  2'd1, 3'd3, 16'd0,       1'b0};
        vecs[15] = '{ACT_NONE,    1'b1, 1'b0, 10'd15, 10'd7, 1,  2'd2, 3'd2, 16'd1,       1'b1};
        vecs[16] = '{ACT_NONE,    1'b1, 1'b0, 10'd15, 10'd7, 60, 2'd1, 3'd2, 16'd61,      1'b0};
        vecs[17] = '{ACT_NONE,    1'b1, 1'b0, 10'd15, 10'd7, 1,  2'd2, 3'd1, 16'd62,      1'b1};
        vecs[18] = '{ACT_FORCE,   1'b0, 1'b0, 10'd0,  10'd0, 1,  2'd2, 3'd1, 16'hFFFF,    1'b1};
        vecs[19] = '{ACT_NONE,    1'b0, 1'b0, 10'd0,  10'd0, 1,  2'd2, 3'd1, 16'hFFFF,    1'b1};

        rst_n      = 1'b0;
        cif.hc     = 10'd7;
        cif.vc     = 10'd4;
        cif.CrocIn = 1'b0;
        cif.FrogIn = 1'b0;
        cif.Start  = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");

        rst_n = 1'b1;
        step();
        cif.Start = 1'b1;
        step();
        cif.Start = 1'b0;
        chk("start State", 32'(cif.State), 32'd1);
        chk("start Lives", 32'(cif.Lives), 32'd3);
        chk("start Score", 32'(cif.Score), 32'd0);

        for (int i = 0; i < 20; i++) begin
            ovEn   = vecs[i].ovEn;
            ovOnce = vecs[i].ovOnce;
            ovH    = vecs[i].ovH;
            ovV    = vecs[i].ovV;
            if (vecs[i].act == ACT_RESTART) begin
                wait_tick(ok);
                cif.Start = 1'b1;
                step();
                cif.Start = 1'b0;
            end
            if (vecs[i].act == ACT_FORCE) begin
                force dut.scoreQ = 16'hFFFE;
                step();
                release dut.scoreQ;
            end
            run_ticks(vecs[i].nTicks);
            chk($sformatf("row%0d State", i), 32'(cif.State), 32'(vecs[i].expState));
            chk($sformatf("row%0d Lives", i), 32'(cif.Lives), 32'(vecs[i].expLives));
            chk($sformatf("row%0d Score", i), 32'(cif.Score), 32'(vecs[i].expScore));
            chk($sformatf("row%0d Flash", i), 32'(cif.Flash), 32'(vecs[i].expFlash));
        end

        // asynchronous reset mid-cycle while in HIT with Flash high
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
